// File: rtl/gcbp_line_gen_param.sv
// GCBP successor line generator: extracts one (optionally gray-coded) bit plane per luma
// pixel and packs each horizontal sub-image window into a word for the sub-image BRAM writer.
module gcbp_line_gen_param #(
  parameter int C_LUMA_WIDTH      = 9,
  parameter int C_SUBIMAGE_WIDTH  = 128,
  parameter int C_NUM_SUBIMAGES   = 4,
  parameter int C_PIXELS_PER_LINE = 720,
  parameter int C_EDGE_GAP        = 41,
  parameter int C_INNER_GAP       = 42,
  parameter int C_CNT_BITS        = 10,
  parameter int C_SUB_BITS        = 2,
  parameter int C_LINE_BITS       = 10
) (
  input  logic                        i_clk,
  input  logic                        i_resetn,
  input  logic [C_LUMA_WIDTH-1:0]     i_luma_data,
  input  logic                        i_luma_data_valid,
  input  logic                        i_new_line,
  input  logic                        i_new_frame,
  input  logic [3:0]                  i_bit_plane,
  input  logic                        i_gray_en,
  input  logic                        i_line_ready,
  output logic [C_SUBIMAGE_WIDTH-1:0] o_line,
  output logic                        o_line_valid,
  output logic [C_SUB_BITS-1:0]       o_subimage_idx,
  output logic [C_LINE_BITS-1:0]      o_line_num,
  output logic                        o_overflow
);

  // state     | meaning
  // S_IDLE    | no line seen since reset
  // S_GAP     | counting pixels up to the start of window r_sub
  // S_CAPTURE | shifting plane bits of window r_sub
  // S_TAIL    | last window done, ignoring the rest of the line
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GAP     = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_TAIL    = 2'd3;

  localparam int                    C_STRIDE     = C_SUBIMAGE_WIDTH + C_INNER_GAP;
  localparam logic [3:0]            C_KMAX       = 4'(C_LUMA_WIDTH - 1);
  localparam logic [C_SUB_BITS-1:0] C_LAST_SUB   = C_SUB_BITS'(C_NUM_SUBIMAGES - 1);
  localparam logic [C_CNT_BITS-1:0] C_PPL        = C_CNT_BITS'(C_PIXELS_PER_LINE);
  localparam logic [1:0]            C_LINE_ENTRY = (C_EDGE_GAP == 0) ? S_CAPTURE : S_GAP;
  localparam logic [1:0]            C_NEXT_WIN   = (C_INNER_GAP == 0) ? S_CAPTURE : S_GAP;

  logic [1:0]                  r_state;
  logic [C_SUB_BITS-1:0]       r_sub;
  logic [C_CNT_BITS-1:0]       r_pix;
  logic [C_SUBIMAGE_WIDTH-2:0] r_shift;
  logic [C_LINE_BITS-1:0]      r_line;
  logic                        r_first;
  logic [3:0]                  r_plane;
  logic                        r_gray;

  logic [1:0]                  w_state;
  logic [C_SUB_BITS-1:0]       w_sub;
  logic [C_CNT_BITS-1:0]       w_pix;
  logic [C_SUBIMAGE_WIDTH-2:0] w_shift;
  logic [3:0]                  w_k;
  logic                        w_gray;
  logic [1:0]                  w_luma_sh;
  logic                        w_bit;
  logic                        w_beat;
  logic [31:0]                 w_p32;
  logic [31:0]                 w_start;
  logic [31:0]                 w_end;
  logic                        w_gap_hit;
  logic                        w_cap;
  logic                        w_done;
  logic                        w_xfer;
  logic [C_SUBIMAGE_WIDTH-1:0] w_word;
  logic [C_LINE_BITS-1:0]      w_line_nxt;
  logic [C_LINE_BITS-1:0]      w_line_tag;

  // A new-line pulse restarts the line in the same cycle, so a coincident beat is pixel 0.
  assign w_state = i_new_line ? C_LINE_ENTRY : r_state;
  assign w_sub   = i_new_line ? '0 : r_sub;
  assign w_pix   = i_new_line ? '0 : r_pix;
  assign w_shift = i_new_line ? '0 : r_shift;
  assign w_k     = i_new_line ? ((i_bit_plane > C_KMAX) ? C_KMAX : i_bit_plane) : r_plane;
  assign w_gray  = i_new_line ? i_gray_en : r_gray;

  // Bit 1 of the shifted sample reads as 0 for the top plane, which gives the plain bit there.
  assign w_luma_sh = 2'(i_luma_data >> w_k);
  assign w_bit     = w_luma_sh[0] ^ (w_gray & w_luma_sh[1]);

  assign w_beat    = i_luma_data_valid && (w_pix < C_PPL);
  assign w_p32     = 32'(w_pix);
  assign w_start   = 32'(C_EDGE_GAP) + 32'(w_sub) * 32'(C_STRIDE);
  assign w_end     = w_start + 32'(C_SUBIMAGE_WIDTH - 1);
  assign w_gap_hit = w_beat && (w_state == S_GAP) && ((w_p32 + 32'd1) == w_start);
  assign w_cap     = w_beat && (w_state == S_CAPTURE);
  assign w_done    = w_cap && (w_p32 == w_end);
  assign w_word    = {w_shift, w_bit};
  assign w_xfer    = o_line_valid && i_line_ready;

  always_comb begin
    w_line_nxt = r_line;
    if (i_new_line) begin
      if (i_new_frame || r_first)
        w_line_nxt = '0;
      else if (r_line != '1)
        w_line_nxt = r_line + C_LINE_BITS'(1);
    end else if (i_new_frame) begin
      w_line_nxt = '0;
    end
  end

  assign w_line_tag = i_new_line ? w_line_nxt : r_line;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state        <= S_IDLE;
      r_sub          <= '0;
      r_pix          <= '0;
      r_shift        <= '0;
      r_line         <= '0;
      r_first        <= 1'b1;
      r_plane        <= '0;
      r_gray         <= 1'b0;
      o_line         <= '0;
      o_line_valid   <= 1'b0;
      o_subimage_idx <= '0;
      o_line_num     <= '0;
      o_overflow     <= 1'b0;
    end else begin
      o_overflow <= 1'b0;
      r_state    <= w_state;
      r_sub      <= w_sub;
      r_shift    <= w_shift;
      r_line     <= w_line_nxt;
      r_pix      <= w_beat ? (w_pix + C_CNT_BITS'(1)) : w_pix;

      if (i_new_line) begin
        r_plane <= w_k;
        r_gray  <= i_gray_en;
        r_first <= 1'b0;
      end else if (i_new_frame) begin
        r_first <= 1'b1;
      end

      if (w_cap)
        r_shift <= w_word[C_SUBIMAGE_WIDTH-2:0];
      if (w_gap_hit)
        r_state <= S_CAPTURE;
      if (w_done) begin
        if (w_sub == C_LAST_SUB) begin
          r_state <= S_TAIL;
        end else begin
          r_state <= C_NEXT_WIN;
          r_sub   <= w_sub + C_SUB_BITS'(1);
        end
      end

      // Single-entry output buffer; a word completing into a stalled full buffer is lost.
      if (w_done && (!o_line_valid || w_xfer)) begin
        o_line         <= w_word;
        o_subimage_idx <= w_sub;
        o_line_num     <= w_line_tag;
        o_line_valid   <= 1'b1;
      end else if (w_done) begin
        o_overflow <= 1'b1;
      end else if (w_xfer) begin
        o_line_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gcbp_line_gen_param.sv
// Directed bench for gcbp_line_gen_param with default parameters: windows 41..168,
// 211..338, 381..508, 551..678; a per-pixel snapshot of the outputs is taken after each beat.
module tb_gcbp_line_gen_param;

  localparam logic [127:0] C_P    = {1'b1, {126{1'b0}}, 1'b1};
  localparam logic [127:0] C_ONES = {128{1'b1}};

  logic         clk = 1'b0;
  logic         resetn;
  logic [8:0]   luma;
  logic         luma_valid;
  logic         new_line;
  logic         new_frame;
  logic [3:0]   bit_plane;
  logic         gray_en;
  logic         line_ready;
  logic [127:0] o_line;
  logic         o_line_valid;
  logic [1:0]   o_subimage_idx;
  logic [9:0]   o_line_num;
  logic         o_overflow;

  int n_chk  = 0;
  int n_fail = 0;
  int n_vs;
  int n_ovf;

  logic         snap_v   [0:719];
  logic         snap_ovf [0:719];
  logic [1:0]   snap_idx [0:719];
  logic [9:0]   snap_ln  [0:719];
  logic [127:0] snap_w   [0:719];

  gcbp_line_gen_param dut (
    .i_clk             (clk),
    .i_resetn          (resetn),
    .i_luma_data       (luma),
    .i_luma_data_valid (luma_valid),
    .i_new_line        (new_line),
    .i_new_frame       (new_frame),
    .i_bit_plane       (bit_plane),
    .i_gray_en         (gray_en),
    .i_line_ready      (line_ready),
    .o_line            (o_line),
    .o_line_valid      (o_line_valid),
    .o_subimage_idx    (o_subimage_idx),
    .o_line_num        (o_line_num),
    .o_overflow        (o_overflow)
  );

  always #5 clk = ~clk;

  // rdy_p: -2 ready always high, -1 ready always low, otherwise ready only on that pixel's beat.
  task automatic run_line(input logic [8:0] base, input logic [8:0] spot, input logic [3:0] plane,
                          input logic gray, input bit toggle, input bit nf, input int npix,
                          input int rdy_p);
    n_vs  = 0;
    n_ovf = 0;
    for (int p = 0; p < npix; p++) begin
      luma_valid = 1'b1;
      luma       = (p == 41 || p == 168) ? spot : base;
      new_line   = (p == 0);
      new_frame  = nf && (p == 0);
      bit_plane  = plane;
      gray_en    = gray;
      line_ready = (rdy_p == -2) ? 1'b1 : (p == rdy_p);
      @(posedge clk); #1;
      snap_v[p]   = o_line_valid;
      snap_ovf[p] = o_overflow;
      snap_idx[p] = o_subimage_idx;
      snap_ln[p]  = o_line_num;
      snap_w[p]   = o_line;
      if (o_line_valid) n_vs++;
      if (o_overflow) n_ovf++;
      new_line  = 1'b0;
      new_frame = 1'b0;
      if (toggle) begin
        luma_valid = 1'b0;
        luma       = 9'h1FF;
        bit_plane  = 4'd0;
        gray_en    = ~gray;
        @(posedge clk); #1;
        if (o_line_valid) n_vs++;
        if (o_overflow) n_ovf++;
      end
    end
    luma_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    luma_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (o_line_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h exp=0", o_line_valid); end
    n_chk++; if (o_line !== 128'd0) begin n_fail++; $display("FAIL reset_line got=%h exp=0", o_line); end
    n_chk++; if (o_subimage_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got=%0h exp=0", o_subimage_idx); end
    n_chk++; if (o_line_num !== 10'd0) begin n_fail++; $display("FAIL reset_ln got=%0h exp=0", o_line_num); end
    n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%0h exp=0", o_overflow); end
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    run_line(9'h000, 9'h010, 4'd4, 1'b0, 1'b0, 1'b0, 720, -2);
    idle(3);
    n_chk++; if (snap_v[167] !== 1'b0) begin n_fail++; $display("FAIL basic_v167 got=%0h exp=0", snap_v[167]); end
    n_chk++; if (snap_v[168] !== 1'b1) begin n_fail++; $display("FAIL basic_v168 got=%0h exp=1", snap_v[168]); end
    n_chk++; if (snap_w[168] !== C_P) begin n_fail++; $display("FAIL basic_word0 got=%h exp=%h", snap_w[168], C_P); end
    n_chk++; if (snap_idx[168] !== 2'd0) begin n_fail++; $display("FAIL basic_idx0 got=%0h exp=0", snap_idx[168]); end
    n_chk++; if (snap_ln[168] !== 10'd0) begin n_fail++; $display("FAIL basic_ln got=%0h exp=0", snap_ln[168]); end
    n_chk++; if (snap_v[169] !== 1'b0) begin n_fail++; $display("FAIL basic_v169 got=%0h exp=0", snap_v[169]); end
    n_chk++; if (snap_v[338] !== 1'b1 || snap_idx[338] !== 2'd1) begin n_fail++; $display("FAIL basic_w1 got v=%0h idx=%0h exp v=1 idx=1", snap_v[338], snap_idx[338]); end
    n_chk++; if (snap_w[338] !== 128'd0) begin n_fail++; $display("FAIL basic_word1 got=%h exp=0", snap_w[338]); end
    n_chk++; if (snap_v[508] !== 1'b1 || snap_idx[508] !== 2'd2) begin n_fail++; $display("FAIL basic_w2 got v=%0h idx=%0h exp v=1 idx=2", snap_v[508], snap_idx[508]); end
    n_chk++; if (snap_v[678] !== 1'b1 || snap_idx[678] !== 2'd3) begin n_fail++; $display("FAIL basic_w3 got v=%0h idx=%0h exp v=1 idx=3", snap_v[678], snap_idx[678]); end
    n_chk++; if (n_vs !== 4) begin n_fail++; $display("FAIL basic_count got=%0d exp=4", n_vs); end
    n_chk++; if (n_ovf !== 0) begin n_fail++; $display("FAIL basic_ovf got=%0d exp=0", n_ovf); end
  endtask

  task automatic test_gray;
    logic [8:0]   t_luma  [0:4] = '{9'h010, 9'h030, 9'h100, 9'h100, 9'h030};
    logic [3:0]   t_plane [0:4] = '{4'd4, 4'd4, 4'd8, 4'd15, 4'd4};
    logic         t_gray  [0:4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [127:0] t_exp   [0:4] = '{C_ONES, 128'd0, C_ONES, C_ONES, C_ONES};
    for (int i = 0; i < 5; i++) begin
      run_line(t_luma[i], t_luma[i], t_plane[i], t_gray[i], 1'b0, 1'b0, 720, -2);
      idle(3);
      n_chk++; if (snap_w[168] !== t_exp[i]) begin n_fail++; $display("FAIL gray%0d_word0 got=%h exp=%h", i, snap_w[168], t_exp[i]); end
      n_chk++; if (snap_w[678] !== t_exp[i]) begin n_fail++; $display("FAIL gray%0d_word3 got=%h exp=%h", i, snap_w[678], t_exp[i]); end
      n_chk++; if (snap_ln[678] !== 10'(i + 1)) begin n_fail++; $display("FAIL gray%0d_ln got=%0d exp=%0d", i, snap_ln[678], i + 1); end
    end
  endtask

  task automatic test_toggle;
    run_line(9'h000, 9'h010, 4'd4, 1'b0, 1'b1, 1'b0, 720, -2);
    idle(3);
    n_chk++; if (snap_v[167] !== 1'b0) begin n_fail++; $display("FAIL toggle_v167 got=%0h exp=0", snap_v[167]); end
    n_chk++; if (snap_v[168] !== 1'b1) begin n_fail++; $display("FAIL toggle_v168 got=%0h exp=1", snap_v[168]); end
    n_chk++; if (snap_w[168] !== C_P) begin n_fail++; $display("FAIL toggle_word0 got=%h exp=%h", snap_w[168], C_P); end
    n_chk++; if (snap_idx[678] !== 2'd3 || snap_w[678] !== 128'd0) begin n_fail++; $display("FAIL toggle_word3 got idx=%0h w=%h exp idx=3 w=0", snap_idx[678], snap_w[678]); end
    n_chk++; if (snap_ln[678] !== 10'd6) begin n_fail++; $display("FAIL toggle_ln got=%0d exp=6", snap_ln[678]); end
    n_chk++; if (n_vs !== 4) begin n_fail++; $display("FAIL toggle_count got=%0d exp=4", n_vs); end
  endtask

  task automatic test_abort;
    run_line(9'h000, 9'h010, 4'd4, 1'b0, 1'b0, 1'b0, 100, -2);
    n_chk++; if (n_vs !== 0) begin n_fail++; $display("FAIL abort_partial got=%0d exp=0", n_vs); end
    run_line(9'h000, 9'h010, 4'd4, 1'b0, 1'b0, 1'b0, 720, -2);
    idle(3);
    n_chk++; if (snap_v[167] !== 1'b0 || snap_v[168] !== 1'b1) begin n_fail++; $display("FAIL abort_timing got v167=%0h v168=%0h exp 0 1", snap_v[167], snap_v[168]); end
    n_chk++; if (snap_w[168] !== C_P) begin n_fail++; $display("FAIL abort_word0 got=%h exp=%h", snap_w[168], C_P); end
    n_chk++; if (snap_ln[168] !== 10'd8) begin n_fail++; $display("FAIL abort_ln got=%0d exp=8", snap_ln[168]); end
    n_chk++; if (n_vs !== 4) begin n_fail++; $display("FAIL abort_count got=%0d exp=4", n_vs); end
  endtask

  task automatic test_frame;
    run_line(9'h000, 9'h010, 4'd4, 1'b0, 1'b0, 1'b1, 720, -2);
    idle(3);
    n_chk++; if (snap_ln[168] !== 10'd0) begin n_fail++; $display("FAIL frame_ln0 got=%0d exp=0", snap_ln[168]); end
    run_line(9'h000, 9'h010, 4'd4, 1'b0, 1'b0, 1'b0, 720, -2);
    idle(3);
    n_chk++; if (snap_ln[508] !== 10'd1) begin n_fail++; $display("FAIL frame_ln1 got=%0d exp=1", snap_ln[508]); end
  endtask

  task automatic test_back_to_back;
    run_line(9'h000, 9'h010, 4'd4, 1'b0, 1'b0, 1'b0, 720, -1);
    n_chk++; if (snap_v[168] !== 1'b1 || snap_w[168] !== C_P) begin n_fail++; $display("FAIL bp_word0 got v=%0h w=%h exp v=1 w=%h", snap_v[168], snap_w[168], C_P); end
    n_chk++; if (snap_ovf[338] !== 1'b1 || snap_ovf[339] !== 1'b0) begin n_fail++; $display("FAIL bp_ovf338 got %0h%0h exp 10", snap_ovf[338], snap_ovf[339]); end
    n_chk++; if (snap_ovf[508] !== 1'b1 || snap_ovf[678] !== 1'b1) begin n_fail++; $display("FAIL bp_ovf508_678 got %0h%0h exp 11", snap_ovf[508], snap_ovf[678]); end
    n_chk++; if (n_ovf !== 3) begin n_fail++; $display("FAIL bp_ovf_count got=%0d exp=3", n_ovf); end
    n_chk++; if (snap_idx[678] !== 2'd0 || snap_w[678] !== C_P || snap_ln[678] !== 10'd2) begin n_fail++; $display("FAIL bp_held got idx=%0h ln=%0d w=%h", snap_idx[678], snap_ln[678], snap_w[678]); end
    line_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (o_line_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%0h exp=0", o_line_valid); end
    run_line(9'h000, 9'h010, 4'd4, 1'b0, 1'b0, 1'b0, 720, 338);
    n_chk++; if (snap_v[337] !== 1'b1 || snap_idx[337] !== 2'd0) begin n_fail++; $display("FAIL b2b_pre got v=%0h idx=%0h exp v=1 idx=0", snap_v[337], snap_idx[337]); end
    n_chk++; if (snap_v[338] !== 1'b1 || snap_idx[338] !== 2'd1) begin n_fail++; $display("FAIL b2b_load got v=%0h idx=%0h exp v=1 idx=1", snap_v[338], snap_idx[338]); end
    n_chk++; if (snap_w[338] !== 128'd0 || snap_ovf[338] !== 1'b0) begin n_fail++; $display("FAIL b2b_word1 got w=%h ovf=%0h exp w=0 ovf=0", snap_w[338], snap_ovf[338]); end
    n_chk++; if (snap_ln[338] !== 10'd3) begin n_fail++; $display("FAIL b2b_ln got=%0d exp=3", snap_ln[338]); end
    n_chk++; if (n_ovf !== 2) begin n_fail++; $display("FAIL b2b_ovf_count got=%0d exp=2", n_ovf); end
    line_ready = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_pending;
    run_line(9'h000, 9'h010, 4'd4, 1'b0, 1'b0, 1'b0, 200, -1);
    n_chk++; if (snap_v[199] !== 1'b1) begin n_fail++; $display("FAIL rp_pending got=%0h exp=1", snap_v[199]); end
    resetn = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (o_line_valid !== 1'b0 || o_line !== 128'd0) begin n_fail++; $display("FAIL rp_cleared got v=%0h w=%h exp 0", o_line_valid, o_line); end
    n_chk++; if (o_subimage_idx !== 2'd0 || o_line_num !== 10'd0 || o_overflow !== 1'b0) begin n_fail++; $display("FAIL rp_tags got idx=%0h ln=%0d ovf=%0h exp 0", o_subimage_idx, o_line_num, o_overflow); end
    resetn = 1'b1;
    idle(2);
    run_line(9'h000, 9'h010, 4'd4, 1'b0, 1'b0, 1'b0, 720, -2);
    idle(3);
    n_chk++; if (snap_v[168] !== 1'b1 || snap_ln[168] !== 10'd0) begin n_fail++; $display("FAIL rp_first_line got v=%0h ln=%0d exp v=1 ln=0", snap_v[168], snap_ln[168]); end
    n_chk++; if (n_vs !== 4) begin n_fail++; $display("FAIL rp_count got=%0d exp=4", n_vs); end
  endtask

  initial begin
    resetn     = 1'b0;
    luma       = '0;
    luma_valid = 1'b0;
    new_line   = 1'b0;
    new_frame  = 1'b0;
    bit_plane  = 4'd0;
    gray_en    = 1'b0;
    line_ready = 1'b1;
    test_reset();
    test_basic();
    test_gray();
    test_toggle();
    test_abort();
    test_frame();
    test_back_to_back();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
